yurut_tamamlama_birimi: RTL and testbench

Parametrised in-order completion stage for the execute (yurut) pipeline. It generalises the fixed set of multi-cycle units to `BIRIM_SAYISI` channels. It records the issue order of multi-cycle operations in a tag queue. It collects results from units that may finish out of order, releases them to GERIYAZ strictly in issue order through one registered output, and applies back-pressure to both the issue side and the units.

---
 rtl/yurut_tamamlama_birimi_pkg.sv | 16 +
 rtl/yurut_tamamlama_birimi_sira_fifo.sv | 63 ++++++
 rtl/yurut_tamamlama_birimi.sv | 107 ++++++++++
 tb/tb_yurut_tamamlama_birimi.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/yurut_tamamlama_birimi_pkg.sv
// Shared definitions for the execute completion stage.
// Unit channel codes and default sizing.
package yurut_tamamlama_birimi_pkg;

  // Mapping of multi-cycle units to completion channel numbers.
  typedef enum logic [1:0] {
    BIRIM_BOLME     = 2'd0,
    BIRIM_BIB       = 2'd1,
    BIRIM_YAPAYZEKA = 2'd2,
    BIRIM_CARPMA    = 2'd3
  } birim_e;

  localparam int BIRIM_SAYISI_VARSAYILAN = 4;
  localparam int DERINLIK_VARSAYILAN     = 4;

endpackage

// File: rtl/yurut_tamamlama_birimi_sira_fifo.sv
// Tag FIFO recording issue order of multi-cycle ops.
// Extra pointer bit separates full from empty.
module yurut_tamamlama_birimi_sira_fifo #(
  parameter int GENISLIK = 8,
  parameter int DERINLIK = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        temizle_i,
  input  logic                        yaz_i,
  input  logic                        oku_i,
  input  logic [GENISLIK-1:0]         veri_i,
  output logic [GENISLIK-1:0]         veri_o,
  output logic                        bos_o,
  output logic                        dolu_o,
  output logic [$clog2(DERINLIK):0]   doluluk_o
);

  localparam int IB = $clog2(DERINLIK);

  logic [IB:0]         yaz_ptr_q, yaz_ptr_d;
  logic [IB:0]         oku_ptr_q, oku_ptr_d;
  logic [GENISLIK-1:0] bellek_q [DERINLIK];
  logic                it, cek;

  assign bos_o     = (yaz_ptr_q == oku_ptr_q);
  assign dolu_o    = (yaz_ptr_q[IB] != oku_ptr_q[IB]) &&
                     (yaz_ptr_q[IB-1:0] == oku_ptr_q[IB-1:0]);
  assign doluluk_o = yaz_ptr_q - oku_ptr_q;
  assign it        = yaz_i & ~dolu_o & ~temizle_i;
  assign cek       = oku_i & ~bos_o & ~temizle_i;
  assign veri_o    = bellek_q[oku_ptr_q[IB-1:0]];

  // Next pointers; flush empties the queue outright.
  always_comb begin
    yaz_ptr_d = yaz_ptr_q;
    oku_ptr_d = oku_ptr_q;
    if (temizle_i) begin
      yaz_ptr_d = '0;
      oku_ptr_d = '0;
    end else begin
      if (it)  yaz_ptr_d = yaz_ptr_q + 1'b1;
      if (cek) oku_ptr_d = oku_ptr_q + 1'b1;
    end
  end

  // Pointer registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      yaz_ptr_q <= '0;
      oku_ptr_q <= '0;
    end else begin
      yaz_ptr_q <= yaz_ptr_d;
      oku_ptr_q <= oku_ptr_d;
    end
  end

  // Entry storage; contents are don't-care while empty.
  always_ff @(posedge clk_i) begin
    if (it) bellek_q[yaz_ptr_q[IB-1:0]] <= veri_i;
  end

endmodule

// File: rtl/yurut_tamamlama_birimi.sv
// In-order completion stage for multi-cycle execute units.
// Results leave in issue order via one output register.
module yurut_tamamlama_birimi
  import yurut_tamamlama_birimi_pkg::*;
#(
  parameter int BIRIM_SAYISI = BIRIM_SAYISI_VARSAYILAN,
  parameter int VERI_BIT     = 32,
  parameter int DERINLIK     = DERINLIK_VARSAYILAN,
  parameter int ADRES_BIT    = 5
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             temizle_i,
  input  logic                             vy_gecerli_i,
  input  logic [$clog2(BIRIM_SAYISI)-1:0]  vy_birim_i,
  input  logic [ADRES_BIT-1:0]             vy_rd_adres_i,
  input  logic                             vy_yaz_i,
  output logic                             vy_hazir_o,
  input  logic [BIRIM_SAYISI-1:0]          birim_gecerli_i,
  input  logic [BIRIM_SAYISI*VERI_BIT-1:0] birim_sonuc_i,
  output logic [BIRIM_SAYISI-1:0]          birim_hazir_o,
  input  logic                             gy_durdur_i,
  output logic                             gy_gecerli_o,
  output logic [ADRES_BIT-1:0]             gy_rd_adres_o,
  output logic [VERI_BIT-1:0]              gy_rd_deger_o,
  output logic                             gy_yaz_o,
  output logic                             bos_o,
  output logic                             dolu_o,
  output logic [$clog2(DERINLIK):0]        doluluk_o
);

  localparam int BB = $clog2(BIRIM_SAYISI);
  localparam int EW = BB + ADRES_BIT + 1;

  logic [EW-1:0]        bas_giris;
  logic [BB-1:0]        bas_birim;
  logic [ADRES_BIT-1:0] bas_rd;
  logic                 bas_yaz;
  logic [VERI_BIT-1:0]  bas_sonuc;
  logic                 cikis_bos, kabul_uygun, cek;

  logic                 gy_gecerli_q, gy_yaz_q;
  logic [ADRES_BIT-1:0] gy_rd_adres_q;
  logic [VERI_BIT-1:0]  gy_rd_deger_q;

  assign vy_hazir_o = ~dolu_o & ~temizle_i;

  yurut_tamamlama_birimi_sira_fifo #(
    .GENISLIK (EW),
    .DERINLIK (DERINLIK)
  ) u_sira_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .temizle_i (temizle_i),
    .yaz_i     (vy_gecerli_i),
    .oku_i     (cek),
    .veri_i    ({vy_birim_i, vy_rd_adres_i, vy_yaz_i}),
    .veri_o    (bas_giris),
    .bos_o     (bos_o),
    .dolu_o    (dolu_o),
    .doluluk_o (doluluk_o)
  );

  assign {bas_birim, bas_rd, bas_yaz} = bas_giris;

  assign cikis_bos   = ~gy_gecerli_q | ~gy_durdur_i;
  assign kabul_uygun = ~bos_o & cikis_bos & ~temizle_i;
  assign cek         = |(birim_hazir_o & birim_gecerli_i);

  // Accept only the head unit and pick its result.
  always_comb begin
    birim_hazir_o = '0;
    bas_sonuc     = '0;
    for (int k = 0; k < BIRIM_SAYISI; k++) begin
      if (bas_birim == BB'(k)) begin
        birim_hazir_o[k] = kabul_uygun;
        bas_sonuc        = birim_sonuc_i[k*VERI_BIT +: VERI_BIT];
      end
    end
  end

  // Output register; writes to x0 are suppressed here.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      gy_gecerli_q  <= 1'b0;
      gy_yaz_q      <= 1'b0;
      gy_rd_adres_q <= '0;
      gy_rd_deger_q <= '0;
    end else if (temizle_i) begin
      gy_gecerli_q <= 1'b0;
      gy_yaz_q     <= 1'b0;
    end else if (cek) begin
      gy_gecerli_q  <= 1'b1;
      gy_rd_adres_q <= bas_rd;
      gy_rd_deger_q <= bas_sonuc;
      gy_yaz_q      <= bas_yaz & (bas_rd != '0);
    end else if (!gy_durdur_i) begin
      gy_gecerli_q <= 1'b0;
    end
  end

  assign gy_gecerli_o  = gy_gecerli_q;
  assign gy_yaz_o      = gy_yaz_q;
  assign gy_rd_adres_o = gy_rd_adres_q;
  assign gy_rd_deger_o = gy_rd_deger_q;

endmodule

// File: tb/tb_yurut_tamamlama_birimi.sv
// Randomised bench for the completion stage.
// Reference: issue-order queue plus per-unit result queues.
module tb_yurut_tamamlama_birimi;

  localparam int NB = 4;
  localparam int VB = 32;
  localparam int D  = 4;
  localparam int AB = 5;
  localparam int BB = $clog2(NB);
  localparam int CB = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          temizle = 1'b0;
  logic          vy_gecerli = 1'b0;
  logic [BB-1:0] vy_birim = '0;
  logic [AB-1:0] vy_rd = '0;
  logic          vy_yaz = 1'b0;
  logic          vy_hazir;
  logic [NB-1:0] birim_gecerli = '0;
  logic [NB*VB-1:0] birim_sonuc = '0;
  logic [NB-1:0] birim_hazir;
  logic          gy_durdur = 1'b0;
  logic          gy_gecerli;
  logic [AB-1:0] gy_rd;
  logic [VB-1:0] gy_deger;
  logic          gy_yaz;
  logic          bos, dolu;
  logic [CB-1:0] doluluk;

  always #5 clk = ~clk;

  yurut_tamamlama_birimi #(
    .BIRIM_SAYISI (NB),
    .VERI_BIT     (VB),
    .DERINLIK     (D),
    .ADRES_BIT    (AB)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .temizle_i       (temizle),
    .vy_gecerli_i    (vy_gecerli),
    .vy_birim_i      (vy_birim),
    .vy_rd_adres_i   (vy_rd),
    .vy_yaz_i        (vy_yaz),
    .vy_hazir_o      (vy_hazir),
    .birim_gecerli_i (birim_gecerli),
    .birim_sonuc_i   (birim_sonuc),
    .birim_hazir_o   (birim_hazir),
    .gy_durdur_i     (gy_durdur),
    .gy_gecerli_o    (gy_gecerli),
    .gy_rd_adres_o   (gy_rd),
    .gy_rd_deger_o   (gy_deger),
    .gy_yaz_o        (gy_yaz),
    .bos_o           (bos),
    .dolu_o          (dolu),
    .doluluk_o       (doluluk)
  );

  always @(posedge clk) begin
    if (rst_ni && vy_gecerli)
      assert (int'(vy_birim) < NB)
        else $error("vy_birim out of range");
  end

  typedef struct {
    int          birim;
    int          rd;
    bit          yaz;
    logic [31:0] deger;
  } etiket_t;

  etiket_t     kuyruk[$];
  logic [31:0] uval[NB][$];
  int          usay[NB][$];
  bit          m_gv, m_gy;
  int          m_rd;
  logic [31:0] m_deger;

  int vektor = 0;
  int hata = 0;

  task automatic kontrol(input string etiket,
                         input logic [63:0] gozlenen,
                         input logic [63:0] beklenen);
    vektor++;
    if (gozlenen !== beklenen) begin
      hata++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               etiket, gozlenen, beklenen, $time);
    end
  endtask

  task automatic model_sifirla();
    kuyruk.delete();
    for (int k = 0; k < NB; k++) begin
      uval[k].delete();
      usay[k].delete();
    end
    m_gv = 0; m_gy = 0; m_rd = 0; m_deger = '0;
  endtask

  task automatic durum_kontrol();
    kontrol("doluluk", 64'(doluluk), 64'(kuyruk.size()));
    kontrol("bos", 64'(bos), 64'(kuyruk.size() == 0));
    kontrol("dolu", 64'(dolu), 64'(kuyruk.size() == D));
    kontrol("gy_gecerli", 64'(gy_gecerli), 64'(m_gv));
    kontrol("gy_yaz", 64'(gy_yaz), 64'(m_gy));
    if (m_gv) begin
      kontrol("gy_rd", 64'(gy_rd), 64'(m_rd));
      kontrol("gy_deger", 64'(gy_deger), 64'(m_deger));
    end
  endtask

  // One cycle: drive at negedge, check, advance model.
  task automatic adim(input int p_vy, input int p_dur,
                      input int p_tem, input int gmax);
    logic [NB-1:0] bekl_bh;
    bit            bekl_vh, cb, pop, dolu0;
    etiket_t       e;
    logic [31:0]   v;
    int            g;
    @(negedge clk);
    temizle    = ($urandom_range(99) < p_tem);
    gy_durdur  = ($urandom_range(99) < p_dur);
    vy_gecerli = ($urandom_range(99) < p_vy);
    vy_birim   = BB'($urandom_range(NB-1));
    vy_rd      = AB'($urandom_range(31));
    vy_yaz     = $urandom_range(1) == 1;
    for (int k = 0; k < NB; k++) begin
      birim_gecerli[k] = uval[k].size() > 0 && usay[k][0] == 0;
      birim_sonuc[k*VB +: VB] =
        (uval[k].size() > 0) ? uval[k][0] : $urandom;
    end
    #1;
    bekl_vh = kuyruk.size() < D && !temizle;
    cb      = !m_gv || !gy_durdur;
    bekl_bh = '0;
    if (kuyruk.size() > 0 && cb && !temizle)
      bekl_bh[kuyruk[0].birim] = 1'b1;
    kontrol("vy_hazir", 64'(vy_hazir), 64'(bekl_vh));
    kontrol("birim_hazir", 64'(birim_hazir), 64'(bekl_bh));
    durum_kontrol();
    if (temizle) begin
      model_sifirla_kismi();
    end else begin
      dolu0 = kuyruk.size() == D;
      pop = bekl_bh != 0 && birim_gecerli[kuyruk[0].birim];
      if (pop) begin
        e = kuyruk.pop_front();
        void'(uval[e.birim].pop_front());
        void'(usay[e.birim].pop_front());
        m_gv = 1; m_rd = e.rd; m_deger = e.deger;
        m_gy = e.yaz && e.rd != 0;
      end else if (!gy_durdur) begin
        m_gv = 0;
      end
      for (int k = 0; k < NB; k++)
        if (usay[k].size() > 0 && usay[k][0] > 0)
          usay[k][0] = usay[k][0] - 1;
      if (vy_gecerli && !dolu0) begin
        v = $urandom;
        g = $urandom_range(gmax);
        e.birim = int'(vy_birim); e.rd = int'(vy_rd);
        e.yaz = vy_yaz; e.deger = v;
        kuyruk.push_back(e);
        uval[e.birim].push_back(v);
        usay[e.birim].push_back(g);
      end
    end
  endtask

  // Flush: queue and units empty, output valid drops, rd held.
  task automatic model_sifirla_kismi();
    kuyruk.delete();
    for (int k = 0; k < NB; k++) begin
      uval[k].delete();
      usay[k].delete();
    end
    m_gv = 0; m_gy = 0;
  endtask

  initial begin
    model_sifirla();
    repeat (2) @(negedge clk);
    #1;
    kontrol("rst_vy_hazir", 64'(vy_hazir), 64'd1);
    kontrol("rst_birim_hazir", 64'(birim_hazir), 64'd0);
    kontrol("rst_gy_rd", 64'(gy_rd), 64'd0);
    kontrol("rst_gy_deger", 64'(gy_deger), 64'd0);
    durum_kontrol();
    @(negedge clk);
    rst_ni = 1'b1;

    repeat (300) adim(90, 10, 0, 12);
    repeat (400) adim(60, 20, 2, 3);
    repeat (300) adim(70, 60, 1, 2);
    repeat (400) adim(100, 0, 1, 0);
    repeat (200) adim(50, 30, 5, 5);

    adim(0, 0, 100, 0);
    adim(100, 0, 0, 30);
    adim(100, 0, 0, 30);
    @(negedge clk);
    temizle = 0; vy_gecerli = 0; gy_durdur = 0;
    birim_gecerli = '0;
    #1;
    kontrol("pre_rst_doluluk", 64'(doluluk), 64'd2);
    @(posedge clk);
    #2;
    rst_ni = 1'b0;
    #1;
    model_sifirla();
    kontrol("arst_vy_hazir", 64'(vy_hazir), 64'd1);
    kontrol("arst_birim_hazir", 64'(birim_hazir), 64'd0);
    kontrol("arst_gy_rd", 64'(gy_rd), 64'd0);
    kontrol("arst_gy_deger", 64'(gy_deger), 64'd0);
    durum_kontrol();
    @(negedge clk);
    rst_ni = 1'b1;
    repeat (200) adim(70, 20, 1, 3);

    $display("== %0d vectors applied, %0d miscompares ==",
             vektor, hata);
    $finish;
  end

endmodule
